inst_fetch_unit: RTL and testbench

- Reader side of the local-store instruction path. The bench/loader writes 1024-bit instruction lines (32 × 32-bit instructions) into local store; this block reads those lines back, buffers one line, and issues aligned instruction pairs to the dual-issue (even/odd) decode stage.
- Handles decode back-pressure, line crossing and branch redirect.
- Sits between the local store read port and decode inside top.

---
 rtl/inst_fetch_unit_pkg.sv | 39 +++
 rtl/inst_fetch_unit_line_buf.sv | 65 ++++++
 rtl/inst_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared widths, fetch FSM state encoding and PC/line field helpers for the
// local-store instruction fetch path.
// -----------------------------------------------------------------------------
package inst_fetch_unit_pkg;

   localparam int unsigned LINE_W  = 1024;             // bits per local-store line
   localparam int unsigned INST_W  = 32;               // bits per instruction
   localparam int unsigned LADDR_W = 7;                // line address width
   localparam int unsigned PC_W    = 12;               // {line, slot} word address
   localparam int unsigned SLOT_W  = PC_W - LADDR_W;   // slot index width
   localparam int unsigned PAIR_W  = 2 * INST_W;       // even + odd instruction
   localparam int unsigned OFS_W   = $clog2(INST_W);   // bit offset inside a slot

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ISSUE = 2'd3
   } fetch_state_e;

   // Instruction k of a line occupies bits [32k : 32k+31].
   function automatic logic [INST_W-1:0] slot_inst(input logic [0:LINE_W-1] line,
                                                   input logic [SLOT_W-1:0] slot);
      logic [SLOT_W+OFS_W-1:0] base;
      base = {slot, {OFS_W{1'b0}}};
      return line[base +: INST_W];
   endfunction

   function automatic logic [LADDR_W-1:0] pc_line(input logic [PC_W-1:0] pc);
      return pc[PC_W-1:SLOT_W];
   endfunction

   function automatic logic [SLOT_W-1:0] pc_slot(input logic [PC_W-1:0] pc);
      return pc[SLOT_W-1:0];
   endfunction

endpackage

// File: rtl/inst_fetch_unit_line_buf.sv
// -----------------------------------------------------------------------------
// fetch_line_buf
// Single-line instruction buffer: holds one 1024-bit line, its valid bit and
// line tag, and muxes out the aligned even/odd instruction pair.
//
// Ports:
//   clk, reset    clock / synchronous active-high reset (clears valid + tag)
//   wr_en         load wr_data into the buffer and mark it valid
//   wr_tag        line address of the data being loaded
//   wr_data       1024-bit line, instruction 0 at bit 0
//   rd_pair_idx   pair index (slot >> 1) for the read mux
//   buf_vld       buffer holds a valid line
//   buf_tag       line address of the buffered line
//   rd_pair       {even inst, odd inst} of the selected pair
// -----------------------------------------------------------------------------
module fetch_line_buf
   import inst_fetch_unit_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [LADDR_W-1:0]  wr_tag,
   input  logic [0:LINE_W-1]   wr_data,
   input  logic [SLOT_W-2:0]   rd_pair_idx,
   output logic                buf_vld,
   output logic [LADDR_W-1:0]  buf_tag,
   output logic [0:PAIR_W-1]   rd_pair
);

   logic [0:LINE_W-1]   data_q, data_d;
   logic                vld_q, vld_d;
   logic [LADDR_W-1:0]  tag_q, tag_d;

   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      tag_d  = tag_q;
      if (wr_en) begin
         data_d = wr_data;
         vld_d  = 1'b1;
         tag_d  = wr_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= 1'b0;
         tag_q <= '0;
      end else begin
         vld_q <= vld_d;
         tag_q <= tag_d;
      end
   end

   // Line contents need no reset: they are only observed while vld_q is set.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign buf_vld = vld_q;
   assign buf_tag = tag_q;
   assign rd_pair = {slot_inst(data_q, {rd_pair_idx, 1'b0}),
                     slot_inst(data_q, {rd_pair_idx, 1'b1})};

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Reads 1024-bit instruction lines from local store, buffers one line and
// issues aligned even/odd instruction pairs to decode. Handles decode stall,
// line crossing (line 127 wraps to 0) and branch redirect.
//
// Ports:
//   clk, reset     clock / synchronous active-high reset
//   ls_rd_req      one-cycle read request pulse to local store
//   ls_rd_addr     line address, valid with ls_rd_req
//   ls_rd_data     line data, instruction k at bits [32k:32k+31]
//   ls_rd_valid    ls_rd_data valid this cycle
//   dec_pair       {even-slot inst, odd-slot inst}
//   dec_slot_vld   per-slot valid, [0] even, [1] odd
//   dec_valid      pair presented
//   dec_pc         PC of the even slot
//   dec_stall      decode cannot accept this cycle
//   br_taken       redirect pulse
//   br_target      redirect word address
// -----------------------------------------------------------------------------
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   output logic                 ls_rd_req,
   output logic [0:LADDR_W-1]   ls_rd_addr,
   input  logic [0:LINE_W-1]    ls_rd_data,
   input  logic                 ls_rd_valid,
   output logic [0:PAIR_W-1]    dec_pair,
   output logic [0:1]           dec_slot_vld,
   output logic                 dec_valid,
   output logic [0:PC_W-1]      dec_pc,
   input  logic                 dec_stall,
   input  logic                 br_taken,
   input  logic [0:PC_W-1]      br_target
);

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   fetch_state_e          state_q, state_d;
   logic [PC_W-1:0]       pc_q, pc_d;
   logic                  drop_q, drop_d;     // discard the outstanding response
   logic                  bubble_q, bubble_d; // suppress issue the cycle after a redirect

   logic [PC_W-1:0]       br_tgt;
   logic [PC_W-1:0]       pc_seq;
   logic                  issue_vld;
   logic                  accept;
   logic                  seq_wrap;
   logic                  tgt_hit;
   logic                  buf_wr;
   logic                  buf_vld;
   logic [LADDR_W-1:0]    buf_tag;
   logic [0:PAIR_W-1]     buf_pair;

   fetch_line_buf u_line_buf (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (buf_wr),
      .wr_tag      (pc_line(pc_q)),
      .wr_data     (ls_rd_data),
      .rd_pair_idx (pc_q[SLOT_W-1:1]),
      .buf_vld     (buf_vld),
      .buf_tag     (buf_tag),
      .rd_pair     (buf_pair)
   );

   assign br_tgt    = br_target;
   assign issue_vld = (state_q == ST_ISSUE) && !bubble_q;
   assign accept    = issue_vld && !dec_stall;
   assign pc_seq    = (pc_q | PC_ONE) + PC_ONE;
   assign seq_wrap  = (pc_slot(pc_seq) == '0);
   assign tgt_hit   = buf_vld && (buf_tag == pc_line(br_tgt));

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      drop_d   = drop_q;
      bubble_d = 1'b0;
      buf_wr   = 1'b0;

      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (ls_rd_valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  buf_wr  = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (accept) begin
               pc_d = pc_seq;
               if (seq_wrap) begin
                  state_d = ST_REQ;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Redirect overrides everything above. A request leaving this cycle
      // (REQ) or already in flight (WAIT) must still be absorbed, so those
      // states park in WAIT with the drop flag set to keep one request
      // outstanding at most.
      if (br_taken) begin
         pc_d     = br_tgt;
         bubble_d = 1'b1;
         buf_wr   = 1'b0;
         case (state_q)
            ST_REQ: begin
               drop_d  = 1'b1;
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (ls_rd_valid) begin
                  drop_d  = 1'b0;
                  state_d = tgt_hit ? ST_ISSUE : ST_REQ;
               end else begin
                  drop_d  = 1'b1;
                  state_d = ST_WAIT;
               end
            end
            default: state_d = tgt_hit ? ST_ISSUE : ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         drop_q   <= 1'b0;
         bubble_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         drop_q   <= drop_d;
         bubble_q <= bubble_d;
      end
   end

   // Outputs are zero whenever they are not qualified, so reset and idle
   // cycles present an all-zero interface.
   always_comb begin
      ls_rd_req    = (state_q == ST_REQ);
      ls_rd_addr   = '0;
      dec_valid    = issue_vld;
      dec_pair     = '0;
      dec_pc       = '0;
      dec_slot_vld = '0;
      if (state_q == ST_REQ) begin
         ls_rd_addr = pc_line(pc_q);
      end
      if (issue_vld) begin
         dec_pair     = buf_pair;
         dec_pc       = {pc_q[PC_W-1:1], 1'b0};
         dec_slot_vld = pc_q[0] ? 2'b01 : 2'b11;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed bench for inst_fetch_unit. Instruction contents are a function of
// their word address (32'h1000_0000 + pc) so every pair is predictable.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

   logic          clk;
   logic          reset;
   logic          ls_rd_req;
   logic [0:6]    ls_rd_addr;
   logic [0:1023] ls_rd_data;
   logic          ls_rd_valid;
   logic [0:63]   dec_pair;
   logic [0:1]    dec_slot_vld;
   logic          dec_valid;
   logic [0:11]   dec_pc;
   logic          dec_stall;
   logic          br_taken;
   logic [0:11]   br_target;

   int unsigned   n_checks = 0;
   int unsigned   n_errors = 0;

   inst_fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .ls_rd_req    (ls_rd_req),
      .ls_rd_addr   (ls_rd_addr),
      .ls_rd_data   (ls_rd_data),
      .ls_rd_valid  (ls_rd_valid),
      .dec_pair     (dec_pair),
      .dec_slot_vld (dec_slot_vld),
      .dec_valid    (dec_valid),
      .dec_pc       (dec_pc),
      .dec_stall    (dec_stall),
      .br_taken     (br_taken),
      .br_target    (br_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] inst_of(input logic [11:0] pc);
      return 32'h1000_0000 + {20'd0, pc};
   endfunction

   function automatic logic [63:0] pair_of(input logic [11:0] pc);
      return {inst_of({pc[11:1], 1'b0}), inst_of({pc[11:1], 1'b1})};
   endfunction

   function automatic logic [0:1023] line_data(input logic [31:0] base);
      logic [0:1023] l = '0;
      for (int k = 0; k < 32; k++) l = {l[32:1023], base + 32'(k)};
      return l;
   endfunction

   function automatic logic [31:0] line_base(input logic [6:0] line);
      return 32'h1000_0000 + {20'd0, line, 5'd0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_issue(input string tag, input logic [11:0] pc);
      check_val({tag, " valid"}, 64'(dec_valid), 64'd1);
      check_val({tag, " pc"}, 64'(dec_pc), 64'({pc[11:1], 1'b0}));
      check_val({tag, " slot_vld"}, 64'(dec_slot_vld), pc[0] ? 64'd1 : 64'd3);
      check_val({tag, " pair"}, dec_pair, pair_of(pc));
   endtask

   task automatic expect_req(input string tag, input logic [6:0] line);
      check_val({tag, " req"}, 64'(ls_rd_req), 64'd1);
      check_val({tag, " addr"}, 64'(ls_rd_addr), 64'(line));
   endtask

   initial begin
      reset       = 1'b1;
      ls_rd_data  = '0;
      ls_rd_valid = 1'b0;
      dec_stall   = 1'b0;
      br_taken    = 1'b0;
      br_target   = '0;

      // Reset state
      step();
      step();
      check_val("rst req", 64'(ls_rd_req), 64'd0);
      check_val("rst addr", 64'(ls_rd_addr), 64'd0);
      check_val("rst valid", 64'(dec_valid), 64'd0);
      check_val("rst pair", dec_pair, 64'd0);
      check_val("rst pc", 64'(dec_pc), 64'd0);
      check_val("rst slot_vld", 64'(dec_slot_vld), 64'd0);

      // Release reset: IDLE this cycle, request next cycle
      reset = 1'b0;
      check_val("idle req", 64'(ls_rd_req), 64'd0);
      step();
      expect_req("first", 7'd0);
      step();
      check_val("wait req", 64'(ls_rd_req), 64'd0);
      step();
      step();
      ls_rd_valid = 1'b1;
      ls_rd_data  = line_data(line_base(7'd0));
      check_val("wait valid", 64'(dec_valid), 64'd0);
      step();
      ls_rd_valid = 1'b0;

      // Line 0 streams out one pair per cycle, with a 4-cycle stall at pc 6
      for (int k = 0; k < 16; k++) begin
         expect_issue("run0", 12'(2 * k));
         if (k == 3) begin
            dec_stall = 1'b1;
            for (int s = 0; s < 4; s++) begin
               step();
               expect_issue("stall", 12'd6);
            end
            dec_stall = 1'b0;
         end
         step();
      end
      expect_req("line1", 7'd1);
      check_val("line1 valid", 64'(dec_valid), 64'd0);

      // Branch to line 5 while waiting for line 1: line 1 data must be dropped
      step();
      br_taken  = 1'b1;
      br_target = 12'h0A2;
      step();
      br_taken    = 1'b0;
      ls_rd_valid = 1'b1;
      ls_rd_data  = line_data(32'h2000_0000);
      check_val("drop valid", 64'(dec_valid), 64'd0);
      check_val("drop req", 64'(ls_rd_req), 64'd0);
      step();
      ls_rd_valid = 1'b0;
      expect_req("refetch5", 7'd5);
      step();
      ls_rd_valid = 1'b1;
      ls_rd_data  = line_data(line_base(7'd5));
      step();
      ls_rd_valid = 1'b0;
      expect_issue("br5", 12'h0A2);
      step();
      expect_issue("br5 next", 12'h0A4);

      // Branch to pc 13 from line 5: not buffered, refetch line 0
      br_taken  = 1'b1;
      br_target = 12'd13;
      step();
      br_taken = 1'b0;
      expect_req("refetch0", 7'd0);
      check_val("refetch0 valid", 64'(dec_valid), 64'd0);
      step();
      ls_rd_valid = 1'b1;
      ls_rd_data  = line_data(line_base(7'd0));
      step();
      ls_rd_valid = 1'b0;
      expect_issue("br13 miss", 12'd13);
      step();
      expect_issue("after13", 12'd14);
      step();
      expect_issue("after14", 12'd16);

      // Branch to pc 13 inside the buffered line: no refetch, one bubble
      br_taken  = 1'b1;
      br_target = 12'd13;
      step();
      br_taken = 1'b0;
      check_val("hit bubble", 64'(dec_valid), 64'd0);
      check_val("hit noreq a", 64'(ls_rd_req), 64'd0);
      step();
      expect_issue("br13 hit", 12'd13);
      check_val("hit noreq b", 64'(ls_rd_req), 64'd0);
      step();
      expect_issue("hit next", 12'd14);

      // Last pair of line 127 wraps to line 0
      br_taken  = 1'b1;
      br_target = 12'hFFE;
      step();
      br_taken = 1'b0;
      expect_req("line127", 7'd127);
      step();
      ls_rd_valid = 1'b1;
      ls_rd_data  = line_data(line_base(7'd127));
      step();
      ls_rd_valid = 1'b0;
      expect_issue("last pair", 12'hFFE);
      step();
      expect_req("wrap", 7'd0);

      // Reset while waiting; stale response two cycles later is ignored
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_val("mid rst req", 64'(ls_rd_req), 64'd0);
      check_val("mid rst valid", 64'(dec_valid), 64'd0);
      step();
      ls_rd_valid = 1'b1;
      ls_rd_data  = line_data(32'hBAD0_0000);
      expect_req("post rst", 7'd0);
      step();
      ls_rd_valid = 1'b0;
      check_val("stale valid", 64'(dec_valid), 64'd0);
      ls_rd_valid = 1'b1;
      ls_rd_data  = line_data(line_base(7'd0));
      step();
      ls_rd_valid = 1'b0;
      expect_issue("post rst", 12'd0);
      step();
      expect_issue("post rst next", 12'd2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
